// File: rtl/dsc_s2b.sv
// Stochastic-to-binary decoder: counts ones in a unary bitstream over one
// deterministic frame of 2^(WIDTH*N_IN) enabled cycles and holds the result.
module dsc_s2b #(
    parameter int WIDTH = 10,
    parameter int N_IN  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic                    sn_in,
    output logic                    busy,
    output logic [WIDTH*N_IN-1:0]   z,
    output logic                    ov
);

    localparam int L = WIDTH * N_IN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [L-1:0]   fc;
    logic [L:0]     oc;
    logic [L:0]     oc_nxt;
    logic [L-1:0]   z_nxt;

    // oc carries one extra bit so an all-ones frame (2^L) saturates z instead of wrapping
    always_comb begin
        oc_nxt = oc + {{L{1'b0}}, sn_in};
        z_nxt  = oc_nxt[L] ? '1 : oc_nxt[L-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fc    <= '0;
            oc    <= '0;
            z     <= '0;
            ov    <= 1'b0;
            busy  <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        fc    <= '0;
                        oc    <= '0;
                        z     <= '0;
                        ov    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    oc <= oc_nxt;
                    z  <= z_nxt;
                    fc <= fc + 1'b1;
                    if (fc == '1) begin
                        state <= DONE;
                        ov    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsc_s2b.sv
// Directed bench for dsc_s2b with WIDTH=2, N_IN=2 (16-cycle frames).
module tb_dsc_s2b;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       sn_in;
    logic       busy;
    logic [3:0] z;
    logic       ov;

    int passed;
    int total;

    dsc_s2b #(.WIDTH(2), .N_IN(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .sn_in (sn_in),
        .busy  (busy),
        .z     (z),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_start();
        en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_samples(input logic [15:0] pat, input int unsigned first,
                                 input int unsigned count);
        for (int unsigned i = first; i < first + count; i++) begin
            sn_in = pat[i];
            tick();
        end
        sn_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b1; sn_in = 1'b1;
        tick();
        tick();
        total++;
        if (z !== 4'd0) $display("FAIL reset_z: got %0d want 0", z); else passed++;
        total++;
        if (ov !== 1'b0) $display("FAIL reset_ov: got %b want 0", ov); else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst = 1'b0; start = 1'b0; sn_in = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_normal();
        logic [15:0] pat;
        pat = 16'b0101_1101_0110_1001;
        accept_start();
        total++;
        if (busy !== 1'b1 || z !== 4'd0 || ov !== 1'b0)
            $display("FAIL normal_accept: got busy=%b z=%0d ov=%b want 1 0 0", busy, z, ov);
        else passed++;
        drive_samples(pat, 0, 8);
        total++;
        if (z !== 4'd4) $display("FAIL normal_track_z: got %0d want 4", z); else passed++;
        drive_samples(pat, 8, 7);
        total++;
        if (ov !== 1'b0 || busy !== 1'b1)
            $display("FAIL normal_early_ov: got ov=%b busy=%b want 0 1", ov, busy);
        else passed++;
        drive_samples(pat, 15, 1);
        total++;
        if (ov !== 1'b1 || busy !== 1'b0 || z !== 4'd9)
            $display("FAIL normal_done: got ov=%b busy=%b z=%0d want 1 0 9", ov, busy, z);
        else passed++;
        tick();
        total++;
        if (ov !== 1'b1 || z !== 4'd9)
            $display("FAIL normal_hold: got ov=%b z=%0d want 1 9", ov, z);
        else passed++;
    endtask

    task automatic test_boundary();
        accept_start();
        drive_samples(16'h0000, 0, 16);
        total++;
        if (ov !== 1'b1 || z !== 4'd0)
            $display("FAIL bound_zeros: got ov=%b z=%0d want 1 0", ov, z);
        else passed++;
        accept_start();
        drive_samples(16'hFFFF, 0, 16);
        total++;
        if (ov !== 1'b1 || z !== 4'd15)
            $display("FAIL bound_ones: got ov=%b z=%0d want 1 15", ov, z);
        else passed++;
    endtask

    task automatic test_stall();
        logic [15:0] pat;
        pat = 16'b0000_0011_0101_0101;
        accept_start();
        drive_samples(pat, 0, 8);
        total++;
        if (z !== 4'd4) $display("FAIL stall_pre_z: got %0d want 4", z); else passed++;
        en = 1'b0; sn_in = 1'b1; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (z !== 4'd4 || busy !== 1'b1 || ov !== 1'b0)
                $display("FAIL stall_hold_%0d: got z=%0d busy=%b ov=%b want 4 1 0", k, z, busy, ov);
            else passed++;
        end
        en = 1'b1; start = 1'b0;
        drive_samples(pat, 8, 7);
        total++;
        if (ov !== 1'b0) $display("FAIL stall_early_ov: got %b want 0 at edge 20", ov); else passed++;
        drive_samples(pat, 15, 1);
        total++;
        if (ov !== 1'b1 || z !== 4'd6)
            $display("FAIL stall_done: got ov=%b z=%0d want 1 6", ov, z);
        else passed++;
    endtask

    task automatic test_restart();
        accept_start();
        drive_samples(16'b0101_1101_0110_1001, 0, 16);
        total++;
        if (z !== 4'd9 || ov !== 1'b1)
            $display("FAIL restart_pre: got z=%0d ov=%b want 9 1", z, ov);
        else passed++;
        accept_start();
        total++;
        if (z !== 4'd0 || ov !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_clear: got z=%0d ov=%b busy=%b want 0 0 1", z, ov, busy);
        else passed++;
        drive_samples(16'b0010_0000_1000_0100, 0, 16);
        total++;
        if (z !== 4'd3 || ov !== 1'b1)
            $display("FAIL restart_done: got z=%0d ov=%b want 3 1", z, ov);
        else passed++;
    endtask

    task automatic test_back_to_back();
        accept_start();
        start = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            sn_in = (i % 3 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        total++;
        if (ov !== 1'b1 || z !== 4'd6 || busy !== 1'b0)
            $display("FAIL b2b_done: got ov=%b z=%0d busy=%b want 1 6 0", ov, z, busy);
        else passed++;
        sn_in = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || ov !== 1'b0 || z !== 4'd0)
            $display("FAIL b2b_restart: got busy=%b ov=%b z=%0d want 1 0 0", busy, ov, z);
        else passed++;
        start = 1'b0;
        drive_samples(16'h0000, 0, 16);
        total++;
        if (ov !== 1'b1 || z !== 4'd0)
            $display("FAIL b2b_second: got ov=%b z=%0d want 1 0", ov, z);
        else passed++;
    endtask

    task automatic test_abort();
        accept_start();
        drive_samples(16'hFFFF, 0, 7);
        total++;
        if (z !== 4'd7) $display("FAIL abort_pre_z: got %0d want 7", z); else passed++;
        rst = 1'b1; sn_in = 1'b1;
        tick();
        total++;
        if (z !== 4'd0 || busy !== 1'b0 || ov !== 1'b0)
            $display("FAIL abort_clear: got z=%0d busy=%b ov=%b want 0 0 0", z, busy, ov);
        else passed++;
        rst = 1'b0; sn_in = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy); else passed++;
        accept_start();
        drive_samples(16'b1001_0110_1011_0001, 0, 16);
        total++;
        if (z !== 4'd8 || ov !== 1'b1)
            $display("FAIL abort_fresh: got z=%0d ov=%b want 8 1", z, ov);
        else passed++;
    endtask

    task automatic test_multiplier();
        int unsigned a;
        int unsigned b;
        logic [15:0] pat;
        a = 3;
        b = 3;
        // operand a as unary over 4 cycles, operand b held for 4-cycle blocks
        for (int unsigned i = 0; i < 16; i++)
            pat[i] = ((i % 4) < a) && ((i / 4) < b);
        accept_start();
        drive_samples(pat, 0, 16);
        total++;
        if (z !== 4'(a * b) || ov !== 1'b1)
            $display("FAIL mult_3x3: got z=%0d ov=%b want %0d 1", z, ov, a * b);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b0; en = 1'b1; start = 1'b0; sn_in = 1'b0;
        test_reset();
        test_normal();
        test_boundary();
        test_stall();
        test_restart();
        test_back_to_back();
        test_abort();
        test_multiplier();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
